control_seq: RTL and testbench
==============================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction/IR width; opcode is always IR[DATA_W-1:DATA_W-4]; legal range 16..32.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning max wait cycles for MEM_READY; 0 disables the timeout.
REQ-003 SHALL have: CLK  in  1  single clock, all state on rising edge.
REQ-004 SHALL have: RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have: INSTR  in  DATA_W  fetched instruction word, valid when MEM_READY=1 in FETCH.
REQ-006 SHALL have: MEM_READY  in  1  memory completion for the current MEM_REQ.
REQ-007 SHALL have: MEM_REQ  out  1  memory access request, held until MEM_READY.
REQ-008 SHALL have: IR  out  DATA_W  registered instruction.
REQ-009 SHALL have: STAGE  out  3  current state encoding.
REQ-010 SHALL have: ALU_CONTROL out 3, ALU_MuxB out 3, and MAR_LE, MEM_WE, RD_LE, REG_CONTROL, PC_CONTROL, PC_LE, IR_LE out 1 each, with the team's existing datapath meanings.
REQ-011 SHALL have: HALT out 1, sticky TRAP stop; TIMEOUT_ERR out 1, sticky memory timeout.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALTED=5, ERROR=6; STAGE SHALL equal the state code.
REQ-013 FETCH: MEM_REQ=1; SHALL stay while MEM_READY=0; on MEM_READY=1, IR<=INSTR, IR_LE=1 in that cycle, next state DECODE.
REQ-014 DECODE -> EXECUTE unconditionally; MAR_LE=1 in DECODE for LDR (0110) and STR (0111) only.
REQ-015 EXECUTE: PC_LE=1. Next state is MEM for LDR/STR. For TRAP (1111) with IR[7:0]=8'h25, next state is HALTED. For all other opcodes, next state is WRITEBACK.
REQ-016 MEM: MEM_REQ=1; MEM_WE=1 for STR only. SHALL stay while MEM_READY=0. On MEM_READY=1, go to WRITEBACK.
REQ-017 WRITEBACK: RD_LE=1 except for STR, BR (0000), JMP (1100), TRAP and RTI (1000); REG_CONTROL=1 for LDR only; next state FETCH.
REQ-018 ALU_CONTROL SHALL be 000 for ADD/LDR/STR, 001 for AND, 010 for NOT, and 100 for MUL (1101) with IR[5]=1. For MUL with IR[5]=0, it SHALL be {1,IR[4:3]}. All others SHALL be 000.
REQ-019 ALU_MuxB SHALL be 100 for ADD/AND with IR[5]=1, 101 for LDR/STR, else 000.
REQ-020 PC_CONTROL SHALL be 1 for BR, JMP, JSR (0100), TRAP and RTI, else 0; it is only sampled when PC_LE=1.
REQ-021 All decoded outputs SHALL be functions of state and registered IR only; there are no combinational paths from INSTR or MEM_READY to outputs, except that IR_LE is qualified by MEM_READY.
REQ-022 Strobes MEM_REQ, MEM_WE, MAR_LE, RD_LE, PC_LE and IR_LE SHALL be 0 in every state not listed for them.
REQ-023 Wait counter: reset to 0 on entry to FETCH/MEM and incremented each cycle MEM_REQ=1 and MEM_READY=0, saturating. Its width SHALL be clog2(MEM_TIMEOUT+1), minimum 1.
REQ-024 If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with MEM_READY still 0, the next state SHALL be ERROR. MEM_READY=1 in that same cycle wins and takes the normal transition.
REQ-025 HALTED and ERROR SHALL be absorbing until reset. All strobes SHALL be 0 in them. HALT=1 only in HALTED and TIMEOUT_ERR=1 only in ERROR.
REQ-026 Latency with MEM_READY tied 1: ADD is 4 cycles FETCH->FETCH; LDR/STR is 5 cycles.
REQ-027 Undefined opcodes (0011, 1010, 1011, 1110) SHALL be treated as no-ops: they traverse WRITEBACK with RD_LE=0.

Reset
REQ-028 While RST_N=0 (asynchronously): state=FETCH, IR=0, wait counter=0, HALT=0, TIMEOUT_ERR=0, and all strobes 0 except MEM_REQ, which SHALL be held 0 until the first clock after release.
REQ-029 Reset asserted mid-access (FETCH/MEM waiting) SHALL abort immediately with no MEM_WE pulse; after release, sequencing SHALL restart at FETCH.

Verification
REQ-030 Bench SHALL cover: MEM_READY=1, INSTR=16'h1261 (ADD imm) -> STAGE 0,1,2,4,0; ALU_MuxB=100; RD_LE=1 only in state 4.
REQ-031 Bench SHALL cover: INSTR=16'h7042 (STR) with MEM_READY low for 3 cycles in MEM -> MEM_WE=1 for 4 cycles; RD_LE never 1; returns to FETCH.
REQ-032 Bench SHALL cover: MEM_TIMEOUT=15 with MEM_READY held 0 in FETCH -> ERROR reached after 15 wait cycles; TIMEOUT_ERR=1 and sticky; MEM_READY=1 exactly at count 15 -> DECODE, no error.
REQ-033 Bench SHALL cover: INSTR=16'hF025 -> HALTED after EXECUTE; HALT=1; no further MEM_REQ until RST_N pulse.
REQ-034 Bench SHALL cover: RST_N low mid-MEM of LDR -> outputs clear without a clock edge; IR=0; next fetch is correct.
REQ-035 Bench SHALL cover: DATA_W=32 with the MUL opcode in bits 31:28 and IR[5]=0, IR[4:3]=10 -> ALU_CONTROL=110.

Source files
------------

// File: rtl/control_seq_if.sv
// ---------------------------------------------------------------------------
// control_seq_if
// Bundles the memory handshake, instruction register and datapath control
// outputs of the control sequencer into one interface.
//
//   master : the sequencer side (control_seq)
//            in : INSTR, MEM_READY
//            out: MEM_REQ, IR, STAGE, ALU_CONTROL, ALU_MuxB, MAR_LE, MEM_WE,
//                 RD_LE, REG_CONTROL, PC_CONTROL, PC_LE, IR_LE, HALT,
//                 TIMEOUT_ERR
//   slave  : the memory / datapath side (directions mirrored)
// ---------------------------------------------------------------------------
interface control_seq_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] INSTR;
    logic              MEM_READY;
    logic              MEM_REQ;
    logic [DATA_W-1:0] IR;
    logic [2:0]        STAGE;
    logic [2:0]        ALU_CONTROL;
    logic [2:0]        ALU_MuxB;
    logic              MAR_LE;
    logic              MEM_WE;
    logic              RD_LE;
    logic              REG_CONTROL;
    logic              PC_CONTROL;
    logic              PC_LE;
    logic              IR_LE;
    logic              HALT;
    logic              TIMEOUT_ERR;

    modport master (
        input  INSTR, MEM_READY,
        output MEM_REQ, IR, STAGE, ALU_CONTROL, ALU_MuxB, MAR_LE, MEM_WE,
               RD_LE, REG_CONTROL, PC_CONTROL, PC_LE, IR_LE, HALT, TIMEOUT_ERR
    );

    modport slave (
        output INSTR, MEM_READY,
        input  MEM_REQ, IR, STAGE, ALU_CONTROL, ALU_MuxB, MAR_LE, MEM_WE,
               RD_LE, REG_CONTROL, PC_CONTROL, PC_LE, IR_LE, HALT, TIMEOUT_ERR
    );
endinterface

// File: rtl/control_seq.sv
// ---------------------------------------------------------------------------
// control_seq
// Multi-cycle control sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] ->
// WRITEBACK, with a sticky HALTED state (TRAP x25) and a sticky ERROR state
// (memory handshake timeout). All decoded outputs come from the state and
// the registered IR; only IR_LE looks at MEM_READY directly.
//
// Ports
//   CLK   : clock, all state on rising edge
//   RST_N : asynchronous active-low reset
//   bus   : control_seq_if.master (handshake, IR, STAGE, datapath controls)
//
// Parameters
//   DATA_W      : instruction width (16..32), opcode in the top 4 bits
//   MEM_TIMEOUT : max wait cycles for MEM_READY, 0 disables the timeout
// ---------------------------------------------------------------------------
module control_seq #(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          RST_N,
    control_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  ir_reg;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    // Low from reset until the first clock after release; keeps MEM_REQ
    // (and therefore any FETCH acceptance) quiet during that window.
    logic               started_reg;

    logic [3:0] opcode;
    logic       is_ldst;
    logic       mem_req;
    logic       accept;
    logic       stall;
    logic       timeout;
    logic       ir_le;

    assign opcode  = ir_reg[DATA_W-1 -: 4];
    assign is_ldst = (opcode == OP_LDR) || (opcode == OP_STR);

    always_comb begin
        mem_req = started_reg && ((state_reg == S_FETCH) || (state_reg == S_MEM));
        accept  = mem_req && bus.MEM_READY;
        stall   = mem_req && !bus.MEM_READY;
        // A ready in the same cycle as the limit wins because stall is then 0.
        timeout = (MEM_TIMEOUT > 0) && stall && (wait_cnt_reg == CNT_LIMIT);
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (timeout)     state_next = S_ERROR;
                else if (accept) state_next = S_DECODE;
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (is_ldst)
                    state_next = S_MEM;
                else if ((opcode == OP_TRAP) && (ir_reg[7:0] == 8'h25))
                    state_next = S_HALTED;
                else
                    state_next = S_WRITEBACK;
            end
            S_MEM: begin
                if (timeout)     state_next = S_ERROR;
                else if (accept) state_next = S_WRITEBACK;
            end
            S_WRITEBACK: state_next = S_FETCH;
            S_HALTED:    state_next = S_HALTED;
            S_ERROR:     state_next = S_ERROR;
            default:     state_next = S_ERROR;
        endcase
    end

    // Wait counter: cleared on every state change (so it starts at 0 on
    // entry to FETCH/MEM), counts stalled request cycles, saturates.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (stall && (wait_cnt_reg != {CNT_W{1'b1}}))
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= S_FETCH;
            ir_reg       <= '0;
            wait_cnt_reg <= '0;
            started_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            started_reg  <= 1'b1;
            if (ir_le)
                ir_reg <= bus.INSTR;
        end
    end

    // Strobes: each is asserted only in its own state, so HALTED/ERROR
    // naturally drive all of them low.
    always_comb begin
        ir_le           = (state_reg == S_FETCH) && accept;
        bus.MEM_REQ     = mem_req;
        bus.IR_LE       = ir_le;
        bus.MAR_LE      = (state_reg == S_DECODE) && is_ldst;
        bus.PC_LE       = (state_reg == S_EXECUTE);
        bus.MEM_WE      = (state_reg == S_MEM) && mem_req && (opcode == OP_STR);
        bus.RD_LE       = (state_reg == S_WRITEBACK) &&
                          !(opcode inside {OP_STR, OP_BR, OP_JMP, OP_TRAP, OP_RTI,
                                           4'h3, 4'hA, 4'hB, 4'hE});
        bus.REG_CONTROL = (opcode == OP_LDR);
        bus.PC_CONTROL  = opcode inside {OP_BR, OP_JMP, OP_JSR, OP_TRAP, OP_RTI};
        bus.HALT        = (state_reg == S_HALTED);
        bus.TIMEOUT_ERR = (state_reg == S_ERROR);
        bus.STAGE       = state_reg;
        bus.IR          = ir_reg;
    end

    // ALU operation and B-operand select, decoded from the registered IR
    always_comb begin
        bus.ALU_CONTROL = 3'b000;
        bus.ALU_MuxB    = 3'b000;
        case (opcode)
            OP_AND: bus.ALU_CONTROL = 3'b001;
            OP_NOT: bus.ALU_CONTROL = 3'b010;
            OP_MUL: bus.ALU_CONTROL = ir_reg[5] ? 3'b100 : {1'b1, ir_reg[4:3]};
            default: bus.ALU_CONTROL = 3'b000;
        endcase
        if (((opcode == OP_ADD) || (opcode == OP_AND)) && ir_reg[5])
            bus.ALU_MuxB = 3'b100;
        else if (is_ldst)
            bus.ALU_MuxB = 3'b101;
    end
endmodule

// File: tb/tb_control_seq.sv
// ---------------------------------------------------------------------------
// tb_control_seq
// Directed and randomized checks of control_seq. dut_a: DATA_W=16,
// MEM_TIMEOUT=15. dut_b: DATA_W=32, MEM_TIMEOUT=0 (timeout disabled).
// Expected values come from instruction-class tables and a path model:
// FETCH waits, DECODE, EXECUTE, optional MEM waits, WRITEBACK.
// ---------------------------------------------------------------------------
module tb_control_seq;
    localparam int TMO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a;
    logic rst_n_b;

    control_seq_if #(.DATA_W(16)) bus_a ();
    control_seq_if #(.DATA_W(32)) bus_b ();

    control_seq #(.DATA_W(16), .MEM_TIMEOUT(TMO)) dut_a (
        .CLK   (clk),
        .RST_N (rst_n_a),
        .bus   (bus_a)
    );

    control_seq #(.DATA_W(32), .MEM_TIMEOUT(0)) dut_b (
        .CLK   (clk),
        .RST_N (rst_n_b),
        .bus   (bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {MEM_REQ, MEM_WE, MAR_LE, RD_LE, PC_LE, IR_LE}
    function automatic logic [5:0] strobes_a();
        return {bus_a.MEM_REQ, bus_a.MEM_WE, bus_a.MAR_LE,
                bus_a.RD_LE, bus_a.PC_LE, bus_a.IR_LE};
    endfunction

    // ---- reference tables by instruction class ----
    function automatic logic [2:0] alu_ref(input logic [3:0] op, input logic b5,
                                           input logic [1:0] b43);
        case (op)
            4'h5:    return 3'b001;
            4'h9:    return 3'b010;
            4'hD:    return b5 ? 3'b100 : {1'b1, b43};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] muxb_ref(input logic [3:0] op, input logic b5);
        if ((op == 4'h1 || op == 4'h5) && b5) return 3'b100;
        if (op == 4'h6 || op == 4'h7)         return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic pc_ref(input logic [3:0] op);
        return op inside {4'h0, 4'hC, 4'h4, 4'hF, 4'h8};
    endfunction

    function automatic logic rd_ref(input logic [3:0] op);
        return !(op inside {4'h7, 4'h0, 4'hC, 4'hF, 4'h8, 4'h3, 4'hA, 4'hB, 4'hE});
    endfunction

    task automatic check_reset_a(input string tag);
        chk({tag, "_stage"},   bus_a.STAGE, 0);
        chk({tag, "_strobes"}, strobes_a(), 0);
        chk({tag, "_ir"},      bus_a.IR, 0);
        chk({tag, "_halt"},    bus_a.HALT, 0);
        chk({tag, "_terr"},    bus_a.TIMEOUT_ERR, 0);
    endtask

    task automatic assert_reset_a();
        @(negedge clk);
        rst_n_a = 1'b0;
        bus_a.MEM_READY = 1'b1;
        #1;
        check_reset_a("rst");
        @(negedge clk);
        #1;
        check_reset_a("rst_hold");
    endtask

    task automatic release_a();
        @(negedge clk);
        rst_n_a = 1'b1;
        bus_a.MEM_READY = 1'b0;
        #1;
        chk("rel_stage",  bus_a.STAGE, 0);
        chk("rel_memreq", bus_a.MEM_REQ, 0);
    endtask

    // Current cycle is already ERROR; confirm it and that it sticks.
    task automatic expect_error_a(input string tag);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus_a.MEM_READY = 1'($urandom);
                #1;
            end
            chk({tag, "_err_stage"},   bus_a.STAGE, 6);
            chk({tag, "_err_terr"},    bus_a.TIMEOUT_ERR, 1);
            chk({tag, "_err_strobes"}, strobes_a(), 0);
            chk({tag, "_err_halt"},    bus_a.HALT, 0);
        end
    endtask

    // One instruction on dut_a, starting in FETCH with MEM_REQ already up.
    // df/dm = stall cycles before MEM_READY in FETCH/MEM; a stall count
    // beyond TMO must end in ERROR. abort_mem >= 0 asserts reset in that
    // MEM cycle (reset is left asserted on return).
    task automatic run_a(input logic [15:0] instr, input int df, input int dm,
                         input int abort_mem);
        logic [3:0] op;
        logic       ldst;
        logic       str;
        logic       halt;
        op   = instr[15:12];
        ldst = (op == 4'h6) || (op == 4'h7);
        str  = (op == 4'h7);
        halt = (op == 4'hF) && (instr[7:0] == 8'h25);
        $display("txn instr=%h fetch_wait=%0d mem_wait=%0d", instr, df, dm);

        for (int i = 0; i <= df; i++) begin
            @(negedge clk);
            bus_a.MEM_READY = (i == df);
            bus_a.INSTR     = (i == df) ? instr : 16'($urandom);
            #1;
            if (i > TMO) begin
                expect_error_a("fetch");
                return;
            end
            chk("fetch_stage",   bus_a.STAGE, 0);
            chk("fetch_strobes", strobes_a(), {1'b1, 4'b0000, (i == df)});
        end

        @(negedge clk);
        bus_a.MEM_READY = 1'($urandom);
        bus_a.INSTR     = 16'($urandom);
        #1;
        chk("dec_stage",   bus_a.STAGE, 1);
        chk("dec_strobes", strobes_a(), {2'b00, ldst, 3'b000});
        chk("dec_ir",      bus_a.IR, instr);

        @(negedge clk);
        bus_a.MEM_READY = 1'($urandom);
        #1;
        chk("exe_stage",   bus_a.STAGE, 2);
        chk("exe_strobes", strobes_a(), 6'b000010);
        chk("exe_pcctl",   bus_a.PC_CONTROL, pc_ref(op));
        chk("exe_alu",     bus_a.ALU_CONTROL, alu_ref(op, instr[5], instr[4:3]));
        chk("exe_muxb",    bus_a.ALU_MuxB, muxb_ref(op, instr[5]));

        if (halt) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bus_a.MEM_READY = 1'($urandom);
                #1;
                chk("halt_stage",   bus_a.STAGE, 5);
                chk("halt_strobes", strobes_a(), 0);
                chk("halt_halt",    bus_a.HALT, 1);
                chk("halt_terr",    bus_a.TIMEOUT_ERR, 0);
            end
            return;
        end

        if (ldst) begin
            for (int j = 0; j <= dm; j++) begin
                @(negedge clk);
                bus_a.MEM_READY = (j == dm);
                bus_a.INSTR     = 16'($urandom);
                #1;
                if (j > TMO) begin
                    expect_error_a("mem");
                    return;
                end
                chk("mem_stage",   bus_a.STAGE, 3);
                chk("mem_strobes", strobes_a(), {1'b1, str, 4'b0000});
                if (j == abort_mem) begin
                    rst_n_a = 1'b0;
                    #1;
                    check_reset_a("abort");
                    return;
                end
            end
        end

        @(negedge clk);
        bus_a.MEM_READY = 1'($urandom);
        #1;
        chk("wb_stage",   bus_a.STAGE, 4);
        chk("wb_strobes", strobes_a(), {3'b000, rd_ref(op), 2'b00});
        chk("wb_regctl",  bus_a.REG_CONTROL, (op == 4'h6));
    endtask

    initial begin
        logic [15:0] rnd_instr;
        int          df;
        int          dm;

        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        bus_a.MEM_READY = 1'b0;
        bus_a.INSTR     = '0;
        bus_b.MEM_READY = 1'b0;
        bus_b.INSTR     = '0;

        assert_reset_a();
        release_a();

        // ADD immediate, then STR with three memory stalls, then LDR
        run_a(16'h1261, 0, 0, -1);
        run_a(16'h7042, 0, 3, -1);
        run_a(16'h6283, 2, 1, -1);

        // Randomized instruction stream (TRAP x25 excluded here)
        for (int t = 0; t < 40; t++) begin
            rnd_instr = 16'($urandom);
            if (rnd_instr[15:12] == 4'hF && rnd_instr[7:0] == 8'h25)
                rnd_instr[7:0] = 8'h24;
            df = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
            dm = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
            run_a(rnd_instr, df, dm, -1);
        end

        // Ready exactly at the limit: normal transition in FETCH and MEM
        run_a(16'h5025, TMO, 0, -1);
        run_a(16'h6A05, 0, TMO, -1);

        // Fetch timeout -> ERROR, sticky until reset
        run_a(16'h1001, TMO + 1, 0, -1);
        assert_reset_a();
        release_a();

        // Memory timeout during STR -> ERROR
        run_a(16'h7E3F, 1, TMO + 1, -1);
        assert_reset_a();
        release_a();

        // TRAP x25 -> HALTED, then reset and confirm fresh sequencing
        run_a(16'hF025, 0, 0, -1);
        assert_reset_a();
        release_a();
        run_a(16'h1261, 0, 0, -1);

        // Reset mid-MEM of LDR, then the next fetch must be correct
        run_a(16'h6A05, 0, 6, 2);
        release_a();
        run_a(16'h9A3F, 1, 0, -1);
        run_a(16'hD018, 0, 0, -1);

        // dut_b: 32-bit IR with MUL opcode in bits 31:28, timeout disabled
        @(negedge clk);
        rst_n_b = 1'b0;
        #1;
        chk("b_rst_stage",  bus_b.STAGE, 0);
        chk("b_rst_memreq", bus_b.MEM_REQ, 0);
        @(negedge clk);
        rst_n_b = 1'b1;
        #1;
        chk("b_rel_memreq", bus_b.MEM_REQ, 0);
        for (int i = 0; i < 2; i++) begin
            $display("txn b instr=%h", (i == 0) ? 32'hD000_0010 : 32'hD000_0020);
            @(negedge clk);
            bus_b.MEM_READY = 1'b1;
            bus_b.INSTR     = (i == 0) ? 32'hD000_0010 : 32'hD000_0020;
            #1;
            chk("b_fetch_irle", bus_b.IR_LE, 1);
            @(negedge clk);
            bus_b.MEM_READY = 1'b0;
            bus_b.INSTR     = '0;
            #1;
            chk("b_dec_ir", bus_b.IR, (i == 0) ? 32'hD000_0010 : 32'hD000_0020);
            @(negedge clk);
            #1;
            chk("b_exe_stage", bus_b.STAGE, 2);
            chk("b_exe_alu",   bus_b.ALU_CONTROL, (i == 0) ? 3'b110 : 3'b100);
            @(negedge clk);
            #1;
            chk("b_wb_rdle", bus_b.RD_LE, 1);
            // Long stall in FETCH: timeout disabled, must never reach ERROR
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                #1;
            end
            chk("b_stall_stage",  bus_b.STAGE, 0);
            chk("b_stall_memreq", bus_b.MEM_REQ, 1);
            chk("b_stall_terr",   bus_b.TIMEOUT_ERR, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
